// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding, parity selector values and the
// prescale width/minimum. Used by both the transmitter and the receiver so
// the two directions agree on encoding and bit timing.
package uart_pkg;

  localparam int          PS_W         = 6;     // PRESCALE field width
  localparam int          MIN_PRESCALE = 4;     // smallest usable bit length
  localparam logic        PAR_EVEN     = 1'b0;
  localparam logic        PAR_ODD      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Values below MIN_PRESCALE leave too few clocks per bit for the receiver
  // to sample mid-bit, so both sides run them as MIN_PRESCALE.
  function automatic logic [PS_W-1:0] clamp_prescale(input logic [PS_W-1:0] ps);
    return (ps < PS_W'(MIN_PRESCALE)) ? PS_W'(MIN_PRESCALE) : ps;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer. Counts 0..prescale-1 while enabled and flags the last
// cycle of every bit so the owning FSM can advance.
//   CLK          in   oversampling clock
//   RST          in   async active-low reset
//   en_i         in   count while high; counter held at 0 while low
//   prescale_i   in   clamped bit length in clocks
//   bit_done_o   out  high on the last cycle of each bit (combinational)
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            en_i,
  input  logic [PS_W-1:0] prescale_i,
  output logic            bit_done_o
);

  logic [PS_W-1:0] cnt_q, cnt_d;
  logic            last;

  assign last       = (cnt_q == prescale_i - PS_W'(1));
  assign bit_done_o = en_i & last;

  always_comb begin
    cnt_d = cnt_q + PS_W'(1);
    if (!en_i || last) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_prescaled.sv
// Oversampled-clock UART transmitter. Pulls words from a FIFO via a
// valid/ack handshake and sends start, DW data bits (LSB first), optional
// parity and one stop bit, each PRESCALE clocks long.
//   CLK         in   UART oversampling clock
//   RST         in   async active-low reset
//   P_DATA      in   word to send (FIFO read data)
//   DATA_VALID  in   word available (FIFO not empty)
//   PAR_EN      in   insert parity bit after data
//   PAR_TYPE    in   0 even / 1 odd parity
//   PRESCALE    in   clocks per bit, values below 4 run as 4
//   TX_OUT      out  serial line, idle high
//   BUSY        out  high while a frame is on the line
//   DATA_ACK    out  one-cycle pulse: word accepted, pop FIFO
module uart_tx_prescaled
  import uart_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [DW-1:0]   P_DATA,
  input  logic            DATA_VALID,
  input  logic            PAR_EN,
  input  logic            PAR_TYPE,
  input  logic [PS_W-1:0] PRESCALE,
  output logic            TX_OUT,
  output logic            BUSY,
  output logic            DATA_ACK
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  uart_state_e     state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            par_en_q, par_en_d;
  logic            par_type_q, par_type_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tx_q, tx_d, busy_q, busy_d, ack_q, ack_d;
  logic            bit_done, par_bit;

  // Timer runs off the shadowed prescale so a config write mid-frame only
  // takes effect on the next accepted word.
  uart_bit_timer u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .en_i       (state_q != ST_IDLE),
    .prescale_i (ps_q),
    .bit_done_o (bit_done)
  );

  assign par_bit = (^data_q) ^ (par_type_q == PAR_ODD);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    ps_d       = ps_q;
    ack_d      = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      ST_IDLE: if (DATA_VALID) begin
        data_d     = P_DATA;
        par_en_d   = PAR_EN;
        par_type_d = PAR_TYPE;
        ps_d       = clamp_prescale(PRESCALE);
        bit_cnt_d  = '0;
        ack_d      = 1'b1;
        state_d    = ST_START;
      end
      ST_START: if (bit_done) begin
        bit_cnt_d = '0;
        state_d   = ST_DATA;
      end
      ST_DATA: if (bit_done) begin
        if (bit_cnt_q == BW'(DW-1)) state_d = par_en_q ? ST_PARITY : ST_STOP;
        else                        bit_cnt_d = bit_cnt_q + BW'(1);
      end
      ST_PARITY: if (bit_done) state_d = ST_STOP;
      // Returning to IDLE for at least one cycle gives back-to-back words
      // a one-clock-longer stop bit.
      ST_STOP:   if (bit_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered line
    // changes on the same edge as the state.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_cnt_d];
      ST_PARITY: tx_d = par_bit;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      ps_q       <= PS_W'(MIN_PRESCALE);
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      ps_q       <= ps_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  assign TX_OUT   = tx_q;
  assign BUSY     = busy_q;
  assign DATA_ACK = ack_q;

endmodule

// File: tb/tb_uart_tx_prescaled.sv
module tb_uart_tx_prescaled;
  import uart_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYPE = 1'b0;
  logic [5:0] PRESCALE = 6'd8;
  logic       TX_OUT, BUSY, DATA_ACK;

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pt;
    int         ps;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fifo[$];

  uart_tx_prescaled #(.DW(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYPE(PAR_TYPE), .PRESCALE(PRESCALE),
    .TX_OUT(TX_OUT), .BUSY(BUSY), .DATA_ACK(DATA_ACK)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // FIFO read side: pop on ACK, present head word away from the active edge.
  always @(negedge CLK) begin
    if (DATA_ACK === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
    DATA_VALID <= (fifo.size() > 0);
    P_DATA     <= (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line bits: start, data LSB first, optional parity, stop.
  function automatic logic [11:0] frame_bits(input exp_t e);
    logic [11:0] b = '1;
    int ones = $countones(e.data);
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = e.data[i];
    if (e.pe) b[9] = e.pt ? (ones % 2 == 0) : (ones % 2 == 1);
    return b;
  endfunction

  task automatic push_word(input logic [7:0] d, input bit pe, input bit pt, input int ps);
    fifo.push_back(d);
    sb.push_back('{d, pe, pt, ps});
  endtask

  // Waits (bounded) for ACK, then records one bit sample per bit window,
  // whether the line held steady inside each window, and BUSY cycles.
  task automatic capture(input int ps, input int nbits, output logic [11:0] bits,
                         output bit stable, output int busy_len, output bit got_ack,
                         output longint ack_cyc);
    bits = '1; stable = 1'b1; busy_len = 0; got_ack = 1'b0; ack_cyc = 0;
    for (int w = 0; w < 5000 && !got_ack; w++) begin
      @(negedge CLK);
      if (DATA_ACK === 1'b1) got_ack = 1'b1;
    end
    if (!got_ack) return;
    ack_cyc = cyc;
    for (int c = 0; c < nbits * ps; c++) begin
      if (c > 0) @(negedge CLK);
      if (c % ps == 0) bits[c/ps] = TX_OUT;
      else if (TX_OUT !== bits[c/ps]) stable = 1'b0;
      if (c > 0 && DATA_ACK !== 1'b0) stable = 1'b0;
      if (BUSY === 1'b1) busy_len++;
    end
  endtask

  // Scoreboard compare point: pop the oldest expectation and check the frame.
  task automatic score_frame(input string tag, output longint ack_cyc);
    exp_t e;
    logic [11:0] got, want;
    bit st, ok;
    int bl, nb;
    ack_cyc = 0;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    nb = 10 + int'(e.pe);
    want = frame_bits(e);
    capture(e.ps, nb, got, st, bl, ok, ack_cyc);
    if (!ok) begin
      miscompares++;
      $display("FAIL %s ack: no DATA_ACK within 5000 cycles", tag);
      return;
    end
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s bits: got %b want %b", tag, got, want);
    end
    vectors++;
    if (!st) begin
      miscompares++;
      $display("FAIL %s stable: line changed inside a bit or extra ACK, want steady bits", tag);
    end
    vectors++;
    if (bl !== nb * e.ps) begin
      miscompares++;
      $display("FAIL %s busy_len: got %0d want %0d", tag, bl, nb * e.ps);
    end
    @(negedge CLK);
    vectors++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post_idle: TX_OUT=%b BUSY=%b want 1/0", tag, TX_OUT, BUSY);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    vectors++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || DATA_ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_val: TX=%b BUSY=%b ACK=%b want 1/0/0", TX_OUT, BUSY, DATA_ACK);
    end
    RST = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      vectors++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || DATA_ACK !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold[%0d]: TX=%b BUSY=%b ACK=%b want 1/0/0", i, TX_OUT, BUSY, DATA_ACK);
      end
    end
  endtask

  task automatic test_basic();
    longint a;
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYPE = 1'b0;
    push_word(8'hA5, 1'b0, 1'b0, 8);
    score_frame("basic_A5", a);
  endtask

  task automatic test_parity();
    longint a;
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYPE = PAR_EVEN;
    push_word(8'h07, 1'b1, 1'b0, 16);
    score_frame("par_even_07", a);
    PAR_TYPE = PAR_ODD;
    push_word(8'h07, 1'b1, 1'b1, 16);
    score_frame("par_odd_07", a);
    PAR_EN = 1'b0; PAR_TYPE = 1'b0;
  endtask

  task automatic test_back_to_back();
    longint a1, a2, a3;
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    push_word(8'h3C, 1'b0, 1'b0, 8);
    push_word(8'hC3, 1'b0, 1'b0, 32);
    push_word(8'h81, 1'b0, 1'b0, 32);
    fork
      score_frame("b2b_0", a1);
      begin
        repeat (30) @(negedge CLK);
        PRESCALE = 6'd32;
      end
    join
    score_frame("b2b_1", a2);
    score_frame("b2b_2", a3);
    vectors++;
    if (a2 - a1 !== 81) begin
      miscompares++;
      $display("FAIL b2b_gap01: got %0d want 81", a2 - a1);
    end
    vectors++;
    if (a3 - a2 !== 321) begin
      miscompares++;
      $display("FAIL b2b_gap12: got %0d want 321", a3 - a2);
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    longint a;
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    fifo.push_back(8'h35);             // aborted frame, never scored
    push_word(8'h96, 1'b0, 1'b0, 8);
    for (int w = 0; w < 2000 && !got; w++) begin
      @(negedge CLK);
      if (DATA_ACK === 1'b1) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rst_mid ack: no DATA_ACK within 2000 cycles");
      return;
    end
    repeat (34) @(negedge CLK);        // frame cycle 34: inside data bit 3
    vectors++;
    if (TX_OUT !== 1'b0 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid pre: TX=%b BUSY=%b want 0/1", TX_OUT, BUSY);
    end
    RST = 1'b0;
    #1;
    vectors++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid async: TX=%b BUSY=%b want 1/0", TX_OUT, BUSY);
    end
    repeat (3) begin
      @(negedge CLK);
      vectors++;
      if (DATA_ACK !== 1'b0 || TX_OUT !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_mid hold: ACK=%b TX=%b want 0/1", DATA_ACK, TX_OUT);
      end
    end
    RST = 1'b1;
    score_frame("rst_mid_fresh", a);
  endtask

  task automatic test_clamp();
    longint a;
    PRESCALE = 6'd2; PAR_EN = 1'b0;
    push_word(8'h5A, 1'b0, 1'b0, 4);
    score_frame("clamp_ps2", a);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
